// File: rtl/gate_selftest.sv
// Exhaustive truth-table checker for a combinational gate: sweeps every input vector,
// compares the sampled output against EXPECT. Optional macro: SELFTEST_STOP_ON_FAIL_EN.
module gate_selftest #(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b0111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_cnt,
  output logic [N_IN-1:0] fail_vec
);

  localparam int              CW   = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   LD   = CW'(SETTLE);
  localparam logic [N_IN-1:0] VMAX = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            mism;
  logic            last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    fail_cnt_d = fail_cnt_q;
    fail_vec_d = fail_vec_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    mism       = (dut_out != EXPECT[vec_q]);
    last       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_SETTLE;
          vec_d      = '0;
          fail_cnt_d = '0;
          fail_vec_d = '0;
          pass_d     = 1'b0;
          cnt_d      = LD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(1)) state_d = S_CHECK;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_CHECK: begin
        if (mism) begin
          fail_cnt_d = fail_cnt_q + (N_IN+1)'(1);
          // fail_cnt still zero means this is the sweep's first mismatch
          if (fail_cnt_q == '0) fail_vec_d = vec_q;
        end
`ifdef SELFTEST_STOP_ON_FAIL_EN
        last = (vec_q == VMAX) || mism;
`else
        last = (vec_q == VMAX);
`endif
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = LD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      vec_q      <= '0;
      fail_cnt_q <= '0;
      fail_vec_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      fail_cnt_q <= fail_cnt_d;
      fail_vec_q <= fail_vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign vec      = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_cnt = fail_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule
